// File: rtl/bali_seq_pkg.sv
// Shared definitions for the bytecode sequencer: the sequencer state
// encoding, the operand/result data width and the return-class opcodes
// that end execution.
package bali_seq_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LATCH,
        DISPATCH,
        ARG_RD,
        ARG_LAT,
        POP,
        EXEC,
        WAIT,
        WB,
        HALT,
        FAULT
    } seq_state_t;

    localparam logic [7:0] OP_IRETURN = 8'hac;
    localparam logic [7:0] OP_ARETURN = 8'hb0;
    localparam logic [7:0] OP_RETURN  = 8'hb1;

    function automatic logic is_return(input logic [7:0] op);
        return (op == OP_RETURN) || (op == OP_IRETURN) || (op == OP_ARETURN);
    endfunction

endpackage

// File: rtl/stack_operand_fetch.sv
// Operand pop loop for the bytecode sequencer.
//   load/load_cnt   arm the loop with the number of operands to pop
//   en              sequencer is in its POP state
//   stack_top/empty operand stack view (combinational)
//   stack_pop       pop strobe, one per captured operand
//   op0..op2        captured operands, op0 = value that was on top
//   done            last pop happens this cycle
//   fault           stack empty while a pop is still owed (no pop issued)
module stack_operand_fetch
    import bali_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [1:0]        load_cnt,
    input  logic              en,
    input  logic [DATA_W-1:0] stack_top,
    input  logic              stack_empty,
    output logic              stack_pop,
    output logic [DATA_W-1:0] op0,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic              done,
    output logic              fault
);

    logic [1:0]        rem_q, rem_d;
    logic [1:0]        idx_q, idx_d;
    logic [DATA_W-1:0] op0_q, op0_d, op1_q, op1_d, op2_q, op2_d;

    always_comb begin
        rem_d     = rem_q;
        idx_d     = idx_q;
        op0_d     = op0_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        stack_pop = 1'b0;
        done      = 1'b0;
        fault     = 1'b0;
        if (load) begin
            rem_d = load_cnt;
            idx_d = 2'd0;
        end else if (en && rem_q != 2'd0) begin
            if (stack_empty) begin
                fault = 1'b1;
            end else begin
                stack_pop = 1'b1;
                case (idx_q)
                    2'd0:    op0_d = stack_top;
                    2'd1:    op1_d = stack_top;
                    default: op2_d = stack_top;
                endcase
                idx_d = idx_q + 2'd1;
                rem_d = rem_q - 2'd1;
                done  = (rem_q == 2'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            idx_q <= '0;
            op0_q <= '0;
            op1_q <= '0;
            op2_q <= '0;
        end else begin
            rem_q <= rem_d;
            idx_q <= idx_d;
            op0_q <= op0_d;
            op1_q <= op1_d;
            op2_q <= op2_d;
        end
    end

    assign op0 = op0_q;
    assign op1 = op1_q;
    assign op2 = op2_q;

endmodule

// File: rtl/bytecode_sequencer.sv
// Fetch/execute controller around an external combinational opcode decoder.
// Fetches an opcode, then sequences immediate fetch, operand pops, one
// execute handshake and an optional push-back; owns the PC and resolves
// GOTO and taken conditional branches.
//   start/start_pc     begin at start_pc when not busy
//   busy/halted/fault  status (halted, fault sticky until rst or start)
//   prog_*             program ROM read port, data one cycle after prog_rd
//   dec_*              opcode out, decode fields in
//   stack_*            operand stack pop/push interface
//   exec_*             execute-unit request/response handshake
module bytecode_sequencer
    import bali_seq_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [ADDR_W-1:0] pc,
    output logic              prog_rd,
    output logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    output logic [7:0]        dec_opcode,
    input  logic [1:0]        dec_argc,
    input  logic [1:0]        dec_stackargs,
    input  logic              dec_stackwb,
    input  logic              dec_isgoto,
    input  logic              dec_iscmp,
    input  logic [DATA_W-1:0] stack_top,
    input  logic              stack_empty,
    output logic              stack_pop,
    output logic              stack_push,
    output logic [DATA_W-1:0] stack_wdata,
    output logic              exec_start,
    output logic [DATA_W-1:0] exec_op0,
    output logic [DATA_W-1:0] exec_op1,
    output logic [DATA_W-1:0] exec_op2,
    output logic [15:0]       exec_arg,
    input  logic              exec_done,
    input  logic [DATA_W-1:0] exec_result,
    input  logic              exec_taken
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] op_pc_q, op_pc_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [15:0]       arg_q, arg_d;
    logic [1:0]        arg_cnt_q, arg_cnt_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              taken_q, taken_d;

    logic              pop_load, pop_en, pop_done, pop_fault;
    logic [ADDR_W-1:0] br_off;

    // Branch offsets are relative to the opcode byte, sign-extended to the PC width.
    assign br_off = ADDR_W'($signed(arg_q));

    stack_operand_fetch u_pop (
        .clk         (clk),
        .rst         (rst),
        .load        (pop_load),
        .load_cnt    (dec_stackargs),
        .en          (pop_en),
        .stack_top   (stack_top),
        .stack_empty (stack_empty),
        .stack_pop   (stack_pop),
        .op0         (exec_op0),
        .op1         (exec_op1),
        .op2         (exec_op2),
        .done        (pop_done),
        .fault       (pop_fault)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        op_pc_d    = op_pc_q;
        opcode_d   = opcode_q;
        arg_d      = arg_q;
        arg_cnt_d  = arg_cnt_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        result_d   = result_q;
        taken_d    = taken_q;
        prog_rd    = 1'b0;
        exec_start = 1'b0;
        stack_push = 1'b0;
        pop_load   = 1'b0;
        pop_en     = 1'b0;
        unique case (state_q)
            IDLE, HALT, FAULT: begin
                if (start) begin
                    pc_d     = start_pc;
                    halted_d = 1'b0;
                    fault_d  = 1'b0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                prog_rd = 1'b1;
                op_pc_d = pc_q;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = LATCH;
            end
            LATCH: begin
                opcode_d = prog_data;
                arg_d    = '0;
                state_d  = DISPATCH;
            end
            DISPATCH: begin
                if (is_return(opcode_q)) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else if (dec_argc == 2'd3) begin
                    fault_d = 1'b1;
                    state_d = FAULT;
                end else if (dec_argc != 2'd0) begin
                    arg_cnt_d = dec_argc;
                    state_d   = ARG_RD;
                end else if (dec_stackargs != 2'd0) begin
                    pop_load = 1'b1;
                    state_d  = POP;
                end else begin
                    state_d = EXEC;
                end
            end
            ARG_RD: begin
                prog_rd = 1'b1;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = ARG_LAT;
            end
            ARG_LAT: begin
                // Shift in so a two-byte immediate ends up big-endian.
                arg_d     = {arg_q[7:0], prog_data};
                arg_cnt_d = arg_cnt_q - 2'd1;
                if (arg_cnt_q > 2'd1) begin
                    state_d = ARG_RD;
                end else if (dec_stackargs != 2'd0) begin
                    pop_load = 1'b1;
                    state_d  = POP;
                end else begin
                    state_d = EXEC;
                end
            end
            POP: begin
                pop_en = 1'b1;
                if (pop_fault) begin
                    fault_d = 1'b1;
                    state_d = FAULT;
                end else if (pop_done) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                exec_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (exec_done) begin
                    result_d = exec_result;
                    taken_d  = exec_taken;
                    state_d  = WB;
                end
            end
            WB: begin
                stack_push = dec_stackwb;
                if (dec_isgoto || (dec_iscmp && taken_q)) begin
                    pc_d = op_pc_q + br_off;
                end
                state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            op_pc_q   <= '0;
            opcode_q  <= '0;
            arg_q     <= '0;
            arg_cnt_q <= '0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
            result_q  <= '0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            op_pc_q   <= op_pc_d;
            opcode_q  <= opcode_d;
            arg_q     <= arg_d;
            arg_cnt_q <= arg_cnt_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
            result_q  <= result_d;
            taken_q   <= taken_d;
        end
    end

    assign busy        = !(state_q inside {IDLE, HALT, FAULT});
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign pc          = pc_q;
    assign prog_addr   = pc_q;
    assign dec_opcode  = opcode_q;
    assign exec_arg    = arg_q;
    assign stack_wdata = result_q;

endmodule

// File: tb/tb_bytecode_sequencer.sv
module tb_bytecode_sequencer;

    typedef struct packed {
        logic [1:0] argc;
        logic [1:0] sa;
        logic       wb;
        logic       gt;
        logic       cmp;
    } dec_t;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [15:0] arg;
    } ex_t;

    typedef logic [15:0] a16_q[$];
    typedef logic [31:0] w32_q[$];
    typedef ex_t         ex_q[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] start_pc = '0;
    logic        busy, halted, fault, prog_rd, stack_pop, stack_push, exec_start;
    logic [15:0] pc, prog_addr, exec_arg;
    logic [7:0]  prog_data = '0;
    logic [7:0]  dec_opcode;
    logic [1:0]  dec_argc, dec_stackargs;
    logic        dec_stackwb, dec_isgoto, dec_iscmp;
    logic [31:0] stack_top = '0;
    logic        stack_empty = 1'b1;
    logic [31:0] stack_wdata, exec_op0, exec_op1, exec_op2;
    logic        exec_done = 1'b0;
    logic [31:0] exec_result = '0;
    logic        exec_taken = 1'b0;

    always #5 clk = ~clk;

    bytecode_sequencer #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
        .busy(busy), .halted(halted), .fault(fault), .pc(pc),
        .prog_rd(prog_rd), .prog_addr(prog_addr), .prog_data(prog_data),
        .dec_opcode(dec_opcode), .dec_argc(dec_argc), .dec_stackargs(dec_stackargs),
        .dec_stackwb(dec_stackwb), .dec_isgoto(dec_isgoto), .dec_iscmp(dec_iscmp),
        .stack_top(stack_top), .stack_empty(stack_empty), .stack_pop(stack_pop),
        .stack_push(stack_push), .stack_wdata(stack_wdata),
        .exec_start(exec_start), .exec_op0(exec_op0), .exec_op1(exec_op1),
        .exec_op2(exec_op2), .exec_arg(exec_arg), .exec_done(exec_done),
        .exec_result(exec_result), .exec_taken(exec_taken)
    );

    // ---------------- environment: decoder, ROM, stack, execute unit ----------------
    function automatic dec_t decode(input logic [7:0] op);
        dec_t d;
        d = '0;
        case (op)
            8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08: d.wb = 1'b1;
            8'h10: begin d.argc = 2'd1; d.wb = 1'b1; end
            8'h60: begin d.sa = 2'd2; d.wb = 1'b1; end
            8'ha7: begin d.argc = 2'd2; d.gt = 1'b1; end
            8'h99: begin d.argc = 2'd2; d.sa = 2'd1; d.cmp = 1'b1; end
            8'hac: d.sa = 2'd1;
            8'hc4: d.argc = 2'd3;
            default: ;
        endcase
        return d;
    endfunction

    dec_t dcd;
    assign dcd           = decode(dec_opcode);
    assign dec_argc      = dcd.argc;
    assign dec_stackargs = dcd.sa;
    assign dec_stackwb   = dcd.wb;
    assign dec_isgoto    = dcd.gt;
    assign dec_iscmp     = dcd.cmp;

    int tk_mode = 2;  // 0/1: forced branch outcome, 2: IFEQ semantics
    int lat_min = 0;
    int lat_max = 0;

    function automatic logic [31:0] exec_res_fn(input logic [7:0] op, input logic [31:0] a0,
                                                input logic [31:0] a1, input logic [15:0] arg);
        case (op)
            8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08: return {24'h0, op} - 32'd3;
            8'h10: return {{24{arg[7]}}, arg[7:0]};
            8'h60: return a0 + a1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exec_tk_fn(input logic [31:0] a0, input int mode);
        if (mode == 2) return (a0 == 32'd0);
        return (mode == 1);
    endfunction

    logic [7:0]  rom [0:255];
    logic [31:0] init_stk[$];
    logic [31:0] stk[$];
    logic [31:0] push_log[$];
    int          pop_cnt;
    logic [15:0] fetch_log[$];
    int          fetch_cyc[$];
    ex_t         exec_log[$];
    int          cyc = 0;
    int unsigned nxt_dly = 0;
    int unsigned ex_wait = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (prog_rd) prog_data <= rom[prog_addr[7:0]];
        if (rst) begin
            fetch_log.delete();
            fetch_cyc.delete();
        end else if (prog_rd) begin
            fetch_log.push_back(prog_addr);
            fetch_cyc.push_back(cyc);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            stk = init_stk;
            push_log.delete();
            pop_cnt <= 0;
        end else begin
            if (stack_pop) begin
                if (stk.size() > 0) void'(stk.pop_back());
                pop_cnt <= pop_cnt + 1;
            end
            if (stack_push) begin
                stk.push_back(stack_wdata);
                push_log.push_back(stack_wdata);
            end
        end
        stack_empty <= (stk.size() == 0);
        stack_top   <= (stk.size() > 0) ? stk[stk.size()-1] : 32'd0;
    end

    always @(posedge clk) begin
        nxt_dly   <= $urandom_range(lat_max, lat_min);
        exec_done <= 1'b0;
        if (rst) begin
            ex_wait <= 0;
            exec_log.delete();
        end else if (exec_start) begin
            exec_result <= exec_res_fn(dec_opcode, exec_op0, exec_op1, exec_arg);
            exec_taken  <= exec_tk_fn(exec_op0, tk_mode);
            exec_log.push_back('{dec_opcode,
                                 (dec_stackargs >= 2'd1) ? exec_op0 : 32'd0,
                                 (dec_stackargs >= 2'd2) ? exec_op1 : 32'd0,
                                 exec_arg});
            if (nxt_dly == 0) exec_done <= 1'b1;
            else ex_wait <= nxt_dly;
        end else if (ex_wait != 0) begin
            ex_wait <= ex_wait - 1;
            if (ex_wait == 1) exec_done <= 1'b1;
        end
    end

    // ---------------- instruction-level reference model ----------------
    logic [15:0] exp_fetch[$];
    ex_t         exp_exec[$];
    logic [31:0] exp_push[$];
    logic [31:0] exp_stk[$];
    int          exp_pops;
    logic        exp_halt, exp_fault;
    logic [15:0] exp_pc;

    task automatic model_run(input logic [15:0] spc);
        logic [15:0] p, ipc, arg;
        logic [7:0]  op;
        logic [31:0] ms[$];
        logic [31:0] a[3];
        logic [31:0] r;
        dec_t        d;
        bit          stop;
        exp_fetch.delete(); exp_exec.delete(); exp_push.delete();
        exp_pops = 0; exp_halt = 0; exp_fault = 0; stop = 0;
        ms = init_stk;
        p = spc;
        for (int n = 0; n < 64 && !stop; n++) begin
            op = rom[p[7:0]];
            exp_fetch.push_back(p);
            ipc = p;
            p = p + 16'd1;
            d = decode(op);
            if (op == 8'hb1 || op == 8'hac || op == 8'hb0) begin
                exp_halt = 1; stop = 1;
            end else if (d.argc == 2'd3) begin
                exp_fault = 1; stop = 1;
            end else begin
                arg = 16'd0;
                for (int i = 0; i < int'(d.argc); i++) begin
                    exp_fetch.push_back(p);
                    arg = {arg[7:0], rom[p[7:0]]};
                    p = p + 16'd1;
                end
                a[0] = 0; a[1] = 0; a[2] = 0;
                for (int k = 0; k < int'(d.sa) && !stop; k++) begin
                    if (ms.size() == 0) begin exp_fault = 1; stop = 1; end
                    else begin a[k] = ms.pop_back(); exp_pops++; end
                end
                if (!stop) begin
                    exp_exec.push_back('{op, a[0], a[1], arg});
                    if (d.wb) begin
                        r = exec_res_fn(op, a[0], a[1], arg);
                        ms.push_back(r);
                        exp_push.push_back(r);
                    end
                    if (d.gt || (d.cmp && exec_tk_fn(a[0], tk_mode))) p = ipc + arg;
                end
            end
        end
        exp_pc  = p;
        exp_stk = ms;
    endtask

    function automatic logic [31:0] mix(input logic [31:0] h, input logic [31:0] v);
        return {h[26:0], h[31:27]} ^ (v + 32'h9e3779b9);
    endfunction
    function automatic logic [31:0] dig_a(input a16_q q);
        logic [31:0] h = q.size();
        foreach (q[i]) h = mix(h, {16'h0, q[i]});
        return h;
    endfunction
    function automatic logic [31:0] dig_w(input w32_q q);
        logic [31:0] h = q.size();
        foreach (q[i]) h = mix(h, q[i]);
        return h;
    endfunction
    function automatic logic [31:0] dig_e(input ex_q q);
        logic [31:0] h = q.size();
        foreach (q[i]) begin
            h = mix(h, {24'h0, q[i].op});
            h = mix(h, q[i].a0);
            h = mix(h, q[i].a1);
            h = mix(h, {16'h0, q[i].arg});
        end
        return h;
    endfunction

    // ---------------- sequencing helpers ----------------
    int errors = 0;
    int checks = 0;

    task automatic apply_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
    endtask

    task automatic do_run(input logic [15:0] spc, output bit timed_out);
        int n;
        @(negedge clk); start_pc = spc; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        timed_out = busy;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'hb1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_rst();
        checks++; if ({busy, halted, fault} !== 3'b000) begin errors++;
            $display("FAIL reset_status: got %b want 000", {busy, halted, fault}); end
        checks++; if ({pc, prog_addr} !== 32'h0) begin errors++;
            $display("FAIL reset_pc: got pc=%h addr=%h want 0", pc, prog_addr); end
        checks++; if ({prog_rd, stack_pop, stack_push, exec_start} !== 4'b0) begin errors++;
            $display("FAIL reset_strobes: got %b want 0000", {prog_rd, stack_pop, stack_push, exec_start}); end
        checks++; if ({dec_opcode, exec_arg, stack_wdata, exec_op0, exec_op1, exec_op2} !== '0) begin errors++;
            $display("FAIL reset_data: op=%h arg=%h wd=%h op0=%h want 0", dec_opcode, exec_arg, stack_wdata, exec_op0); end
    endtask

    task automatic test_iadd();
        bit to;
        clear_rom();
        rom[0] = 8'h04; rom[1] = 8'h05; rom[2] = 8'h60; rom[3] = 8'hb1;
        init_stk.delete(); lat_min = 0; lat_max = 2; tk_mode = 2;
        apply_rst(); model_run(16'h0000); do_run(16'h0000, to);
        checks++; if (to || halted !== 1'b1 || fault !== 1'b0) begin errors++;
            $display("FAIL iadd_halt: got to=%0d halted=%b fault=%b want halted=1", to, halted, fault); end
        checks++; if (exec_log.size() != 3 || exec_log[2].a0 !== 32'd2 || exec_log[2].a1 !== 32'd1) begin errors++;
            $display("FAIL iadd_ops: got n=%0d want op0=2 op1=1", exec_log.size()); end
        checks++; if (dig_w(push_log) !== dig_w(exp_push) || stk.size() != 1 || stk[0] !== 32'd3) begin errors++;
            $display("FAIL iadd_stack: got size=%0d pushes=%0d want [3]", stk.size(), push_log.size()); end
        checks++; if (pc !== 16'h0004 || dig_a(fetch_log) !== dig_a(exp_fetch)) begin errors++;
            $display("FAIL iadd_pc: got pc=%h fetch=%h want pc=0004 fetch=%h", pc, dig_a(fetch_log), dig_a(exp_fetch)); end
    endtask

    task automatic test_bipush();
        bit to;
        clear_rom();
        rom[8'h10] = 8'h10; rom[8'h11] = 8'h7f;
        init_stk.delete();
        apply_rst(); do_run(16'h0010, to);
        checks++; if (exec_log.size() != 1 || exec_log[0].arg !== 16'h007f) begin errors++;
            $display("FAIL bipush_arg: got n=%0d arg=%h want 007f", exec_log.size(),
                     exec_log.size() > 0 ? exec_log[0].arg : 16'hxxxx); end
        checks++; if (fetch_log.size() != 3 || fetch_log[2] !== 16'h0012 || pop_cnt != 0) begin errors++;
            $display("FAIL bipush_next: got n=%0d pops=%0d want fetch 0012 no pops", fetch_log.size(), pop_cnt); end
        checks++; if (to || halted !== 1'b1 || pc !== 16'h0013) begin errors++;
            $display("FAIL bipush_halt: got halted=%b pc=%h want 1 0013", halted, pc); end
    endtask

    task automatic test_goto();
        bit to;
        clear_rom();
        rom[8'h20] = 8'ha7; rom[8'h21] = 8'hff; rom[8'h22] = 8'hfd;
        init_stk.delete();
        apply_rst(); do_run(16'h0020, to);
        checks++; if (fetch_log.size() != 4 || fetch_log[3] !== 16'h001d) begin errors++;
            $display("FAIL goto_target: got n=%0d want 4th fetch 001d", fetch_log.size()); end
        checks++; if (to || halted !== 1'b1 || pc !== 16'h001e) begin errors++;
            $display("FAIL goto_halt: got halted=%b pc=%h want 1 001e", halted, pc); end
    endtask

    task automatic test_ifeq();
        bit to;
        for (int t = 1; t >= 0; t--) begin
            clear_rom();
            rom[8'h40] = 8'h99; rom[8'h41] = 8'h00; rom[8'h42] = 8'h08;
            init_stk.delete(); init_stk.push_back(32'd0); tk_mode = t;
            apply_rst(); do_run(16'h0040, to);
            checks++;
            if (to || fetch_log.size() != 4 || fetch_log[3] !== (t == 1 ? 16'h0048 : 16'h0043) || pop_cnt != 1) begin
                errors++;
                $display("FAIL ifeq_taken%0d: got n=%0d pops=%0d pc=%h want fetch %h", t, fetch_log.size(),
                         pop_cnt, pc, (t == 1 ? 16'h0048 : 16'h0043));
            end
        end
        tk_mode = 2;
    endtask

    task automatic test_faults();
        bit to;
        clear_rom();
        rom[8'h50] = 8'h60; rom[8'h58] = 8'hc4; rom[8'h60] = 8'h04;
        init_stk.delete();
        apply_rst(); do_run(16'h0050, to);
        checks++; if (to || fault !== 1'b1 || halted !== 1'b0 || busy !== 1'b0 || pop_cnt != 0) begin errors++;
            $display("FAIL underflow: got fault=%b halted=%b busy=%b pops=%0d want 1 0 0 0", fault, halted, busy, pop_cnt); end
        do_run(16'h0060, to);
        checks++; if (to || fault !== 1'b0 || halted !== 1'b1) begin errors++;
            $display("FAIL start_clears: got fault=%b halted=%b want 0 1", fault, halted); end
        do_run(16'h0058, to);
        checks++; if (to || fault !== 1'b1 || halted !== 1'b0 || pc !== 16'h0059) begin errors++;
            $display("FAIL argc3: got fault=%b halted=%b pc=%h want 1 0 0059", fault, halted, pc); end
    endtask

    task automatic test_latency();
        bit to;
        clear_rom();
        rom[8'h60] = 8'h04;
        init_stk.delete(); lat_min = 0; lat_max = 0;
        apply_rst(); do_run(16'h0060, to);
        checks++; if (to || fetch_cyc.size() != 2 || (fetch_cyc[1] - fetch_cyc[0]) != 6) begin errors++;
            $display("FAIL latency: got n=%0d delta=%0d want 6", fetch_cyc.size(),
                     fetch_cyc.size() == 2 ? fetch_cyc[1] - fetch_cyc[0] : -1); end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_rom();
        rom[8'h60] = 8'h04;
        init_stk.delete(); lat_min = 8; lat_max = 8;
        apply_rst();
        @(negedge clk); start_pc = 16'h0060; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!exec_start && n < 50) begin @(negedge clk); n++; end
        checks++; if (exec_start !== 1'b1) begin errors++;
            $display("FAIL mid_exec_start: got timeout want exec_start"); end
        @(negedge clk);
        start_pc = 16'h0080; start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (busy !== 1'b1 || pc !== 16'h0061) begin errors++;
            $display("FAIL start_ignored: got busy=%b pc=%h want 1 0061", busy, pc); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, halted, fault, prog_rd, exec_start, stack_pop, stack_push} !== 7'b0 ||
            {pc, prog_addr, dec_opcode, exec_arg} !== '0 || {stack_wdata, exec_op0, exec_op1, exec_op2} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b pc=%h op=%h arg=%h wd=%h want all 0", busy, pc, dec_opcode,
                     exec_arg, stack_wdata);
        end
        rst = 1'b0;
        lat_min = 0; lat_max = 0;
    endtask

    task automatic test_random();
        bit to;
        int a, len, nst;
        for (int it = 0; it < 25; it++) begin
            clear_rom();
            init_stk.delete();
            nst = $urandom_range(2, 0);
            for (int s = 0; s < nst; s++) init_stk.push_back($urandom);
            lat_min = 0; lat_max = $urandom_range(3, 0); tk_mode = 2;
            a = 8'h80;
            len = $urandom_range(8, 1);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(2, 0))
                    0: begin rom[a] = 8'h03 + 8'($urandom_range(5, 0)); a++; end
                    1: begin rom[a] = 8'h10; rom[a+1] = 8'($urandom); a += 2; end
                    default: begin rom[a] = 8'h60; a++; end
                endcase
            end
            rom[a] = 8'hb1;
            apply_rst(); model_run(16'h0080); do_run(16'h0080, to);
            checks++;
            if (to || halted !== exp_halt || fault !== exp_fault || pc !== exp_pc) begin
                errors++;
                $display("FAIL rnd%0d_status: got to=%0d h=%b f=%b pc=%h want h=%b f=%b pc=%h", it, to, halted,
                         fault, pc, exp_halt, exp_fault, exp_pc);
            end
            checks++; if (dig_a(fetch_log) !== dig_a(exp_fetch)) begin errors++;
                $display("FAIL rnd%0d_fetch: got %h want %h", it, dig_a(fetch_log), dig_a(exp_fetch)); end
            checks++; if (dig_e(exec_log) !== dig_e(exp_exec)) begin errors++;
                $display("FAIL rnd%0d_exec: got %h want %h", it, dig_e(exec_log), dig_e(exp_exec)); end
            checks++; if (dig_w(push_log) !== dig_w(exp_push) || pop_cnt != exp_pops) begin errors++;
                $display("FAIL rnd%0d_push_pop: got %h/%0d want %h/%0d", it, dig_w(push_log), pop_cnt,
                         dig_w(exp_push), exp_pops); end
            checks++; if (dig_w(stk) !== dig_w(exp_stk)) begin errors++;
                $display("FAIL rnd%0d_stack: got %h want %h", it, dig_w(stk), dig_w(exp_stk)); end
        end
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_iadd();
        test_bipush();
        test_goto();
        test_ifeq();
        test_faults();
        test_latency();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
